obj_alloc: RTL and testbench

//   Object allocator: the writer side of the object reference table. Claims a free object

---
 rtl/obj_alloc_if.sv | 36 +++
 rtl/obj_alloc.sv | 155 +++++++++++++++
 tb/tb_obj_alloc.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/obj_alloc_if.sv
// Control-unit / table-writer bundle for the object allocator.
// The master side issues requests; the slave side (obj_alloc) reports
// status and drives the object reference table write port.
interface obj_alloc_if #(
  parameter int NUM_OBJ = 8,
  parameter int PTR_W   = 4,
  parameter int ADDR_W  = 16,
  parameter int SIZE_W  = 8
);
  logic               req;
  logic               op;
  logic [SIZE_W-1:0]  size;
  logic [PTR_W-1:0]   free_ptr;
  logic               busy;
  logic               done;
  logic               err;
  logic [1:0]         err_code;
  logic [PTR_W-1:0]   obj_id;
  logic               tbl_wr;
  logic [PTR_W-1:0]   tbl_ptr;
  logic [ADDR_W-1:0]  tbl_loc;
  logic [NUM_OBJ-1:0] live_mask;
  logic [ADDR_W-1:0]  heap_ptr;

  modport master (
    output req, op, size, free_ptr,
    input  busy, done, err, err_code, obj_id,
    input  tbl_wr, tbl_ptr, tbl_loc, live_mask, heap_ptr
  );

  modport slave (
    input  req, op, size, free_ptr,
    output busy, done, err, err_code, obj_id,
    output tbl_wr, tbl_ptr, tbl_loc, live_mask, heap_ptr
  );
endinterface

// File: rtl/obj_alloc.sv
// Object allocator: claims a free slot, hands it the next bump-heap base
// address and writes that base into the object reference table. Free scrubs
// the slot to zero; the heap rewinds only once every slot is free again.
//
// state | meaning
// IDLE  | waiting for req; latches op/size/free_ptr when it arrives
// SCAN  | evaluates the request against live_mask / heap, picks the slot
// WRITE | tbl_wr high for one cycle; live_mask/heap_ptr update on exit
// DONE  | done pulse with obj_id
// ERR   | err pulse with err_code; no table or bookkeeping change
module obj_alloc #(
  parameter int                 NUM_OBJ    = 8,
  parameter int                 PTR_W      = 4,
  parameter int                 ADDR_W     = 16,
  parameter int                 SIZE_W     = 8,
  parameter logic [ADDR_W-1:0]  HEAP_BASE  = 16'h0100,
  parameter logic [ADDR_W-1:0]  HEAP_LIMIT = 16'h1000
) (
  input logic         clk,
  input logic         rst_n,
  obj_alloc_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, SCAN, WRITE, DONE, ERR} state_t;

  state_t             state;
  logic               op_q;
  logic [SIZE_W-1:0]  size_q;
  logic [PTR_W-1:0]   fptr_q;

  logic               free_found;
  logic [PTR_W-1:0]   free_slot;
  logic               ptr_live;
  logic [ADDR_W:0]    heap_sum;
  logic               heap_over;
  logic [NUM_OBJ-1:0] slot_bit;
  logic [NUM_OBJ-1:0] mask_clr;

  // Lowest clear slot, liveness of the requested free slot (out-of-range
  // pointers never match an index, so they read as not live), heap fit check.
  always_comb begin
    free_found = 1'b0;
    free_slot  = '0;
    ptr_live   = 1'b0;
    for (int i = NUM_OBJ - 1; i >= 0; i--) begin
      if (!bus.live_mask[i]) begin
        free_found = 1'b1;
        free_slot  = PTR_W'(i);
      end
    end
    for (int i = 0; i < NUM_OBJ; i++) begin
      if (fptr_q == PTR_W'(i)) ptr_live = bus.live_mask[i];
    end
    heap_sum  = {1'b0, bus.heap_ptr} + {{(ADDR_W + 1 - SIZE_W){1'b0}}, size_q};
    heap_over = heap_sum > {1'b0, HEAP_LIMIT};
    slot_bit  = NUM_OBJ'(1) << bus.tbl_ptr;
    mask_clr  = bus.live_mask & ~slot_bit;
  end

  // Sequencer with registered outputs; tbl_ptr doubles as the working slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      op_q          <= 1'b0;
      size_q        <= '0;
      fptr_q        <= '0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.err       <= 1'b0;
      bus.err_code  <= 2'b00;
      bus.obj_id    <= '0;
      bus.tbl_wr    <= 1'b0;
      bus.tbl_ptr   <= '0;
      bus.tbl_loc   <= '0;
      bus.live_mask <= '0;
      bus.heap_ptr  <= HEAP_BASE;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req) begin
            op_q     <= bus.op;
            size_q   <= bus.size;
            fptr_q   <= bus.free_ptr;
            bus.busy <= 1'b1;
            state    <= SCAN;
          end
        end
        SCAN: begin
          if (!op_q) begin
            if (size_q == '0) begin
              bus.err      <= 1'b1;
              bus.err_code <= 2'b11;
              state        <= ERR;
            end else if (!free_found) begin
              bus.err      <= 1'b1;
              bus.err_code <= 2'b01;
              state        <= ERR;
            end else if (heap_over) begin
              bus.err      <= 1'b1;
              bus.err_code <= 2'b10;
              state        <= ERR;
            end else begin
              bus.tbl_wr  <= 1'b1;
              bus.tbl_ptr <= free_slot;
              bus.tbl_loc <= bus.heap_ptr;
              state       <= WRITE;
            end
          end else begin
            if (!ptr_live) begin
              bus.err      <= 1'b1;
              bus.err_code <= 2'b11;
              state        <= ERR;
            end else begin
              bus.tbl_wr  <= 1'b1;
              bus.tbl_ptr <= fptr_q;
              bus.tbl_loc <= '0;
              state       <= WRITE;
            end
          end
        end
        WRITE: begin
          bus.tbl_wr <= 1'b0;
          if (!op_q) begin
            bus.live_mask <= bus.live_mask | slot_bit;
            bus.heap_ptr  <= bus.heap_ptr + ADDR_W'(size_q);
          end else begin
            bus.live_mask <= mask_clr;
            if (mask_clr == '0) bus.heap_ptr <= HEAP_BASE;
          end
          bus.done   <= 1'b1;
          bus.obj_id <= bus.tbl_ptr;
          state      <= DONE;
        end
        DONE: begin
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        ERR: begin
          bus.err  <= 1'b0;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          bus.busy   <= 1'b0;
          bus.done   <= 1'b0;
          bus.err    <= 1'b0;
          bus.tbl_wr <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_obj_alloc.sv
// Directed bench for obj_alloc: alloc/free sequences, slot exhaustion,
// heap limit, argument errors, heap rewind and reset during a table write.
module tb_obj_alloc;

  logic clk;
  logic rst_n;

  obj_alloc_if #(.NUM_OBJ(8), .PTR_W(4), .ADDR_W(16), .SIZE_W(8)) bus ();

  obj_alloc dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // results of the last run_op
  logic        r_done, r_err;
  logic [1:0]  r_code;
  logic [3:0]  r_id, r_ptr;
  logic [15:0] r_loc;
  int          r_wr, r_lat;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one request from IDLE (called at posedge+1), hold req until done/err
  // is seen, then drop it and return one edge later, back in IDLE.
  task automatic run_op(input logic op_i, input logic [7:0] size_i, input logic [3:0] ptr_i);
    r_done = 0; r_err = 0; r_code = 0; r_id = 0; r_ptr = 0; r_loc = 0;
    r_wr = 0; r_lat = 0;
    bus.req = 1'b1; bus.op = op_i; bus.size = size_i; bus.free_ptr = ptr_i;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (bus.tbl_wr) begin
        r_wr++;
        r_ptr = bus.tbl_ptr;
        r_loc = bus.tbl_loc;
      end
      if (bus.done || bus.err) begin
        r_done = bus.done;
        r_err  = bus.err;
        r_code = bus.err_code;
        r_id   = bus.obj_id;
        r_lat  = k;
        break;
      end
    end
    bus.req = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic expect_ok(input string tag, input logic [3:0] id, input logic [15:0] loc);
    check({tag, " done"},   {31'd0, r_done}, 32'd1);
    check({tag, " lat"},    r_lat, 32'd3);
    check({tag, " wr_cnt"}, r_wr, 32'd1);
    check({tag, " tbl_ptr"}, {28'd0, r_ptr}, {28'd0, id});
    check({tag, " tbl_loc"}, {16'd0, r_loc}, {16'd0, loc});
    check({tag, " obj_id"}, {28'd0, r_id}, {28'd0, id});
  endtask

  task automatic expect_err(input string tag, input logic [1:0] code);
    check({tag, " err"},    {31'd0, r_err}, 32'd1);
    check({tag, " lat"},    r_lat, 32'd2);
    check({tag, " code"},   {30'd0, r_code}, {30'd0, code});
    check({tag, " wr_cnt"}, r_wr, 32'd0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.req = 1'b0; bus.op = 1'b0; bus.size = '0; bus.free_ptr = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // reset values
    check("rst busy",     {31'd0, bus.busy}, 32'd0);
    check("rst done",     {31'd0, bus.done}, 32'd0);
    check("rst err",      {31'd0, bus.err}, 32'd0);
    check("rst tbl_wr",   {31'd0, bus.tbl_wr}, 32'd0);
    check("rst err_code", {30'd0, bus.err_code}, 32'd0);
    check("rst obj_id",   {28'd0, bus.obj_id}, 32'd0);
    check("rst tbl_ptr",  {28'd0, bus.tbl_ptr}, 32'd0);
    check("rst tbl_loc",  {16'd0, bus.tbl_loc}, 32'd0);
    check("rst live",     {24'd0, bus.live_mask}, 32'd0);
    check("rst heap",     {16'd0, bus.heap_ptr}, 32'h0100);

    // 1: single alloc
    run_op(1'b0, 8'h40, 4'd0);
    expect_ok("c1", 4'd0, 16'h0100);
    check("c1 heap", {16'd0, bus.heap_ptr}, 32'h0140);
    check("c1 live", {24'd0, bus.live_mask}, 32'h01);
    check("c1 idle", {31'd0, bus.busy}, 32'd0);

    // 2: fill all slots, then one more
    do_reset();
    for (int i = 0; i < 8; i++) begin
      run_op(1'b0, 8'h10, 4'd0);
      expect_ok($sformatf("c2 a%0d", i), 4'(i), 16'h0100 + 16'(i * 16));
    end
    check("c2 live", {24'd0, bus.live_mask}, 32'hFF);
    check("c2 heap", {16'd0, bus.heap_ptr}, 32'h0180);
    run_op(1'b0, 8'h10, 4'd0);
    expect_err("c2 full", 2'b01);
    check("c2 heap kept", {16'd0, bus.heap_ptr}, 32'h0180);

    // 3: free a slot then reuse it
    run_op(1'b1, 8'h00, 4'd3);
    expect_ok("c3 free", 4'd3, 16'h0000);
    check("c3 live", {24'd0, bus.live_mask}, 32'hF7);
    check("c3 heap", {16'd0, bus.heap_ptr}, 32'h0180);
    run_op(1'b0, 8'h10, 4'd0);
    expect_ok("c3 realloc", 4'd3, 16'h0180);
    check("c3 heap2", {16'd0, bus.heap_ptr}, 32'h0190);

    // 4: walk the heap to 0x0FF0 keeping slot 0 live, then hit the limit
    do_reset();
    run_op(1'b0, 8'hF0, 4'd0);
    for (int i = 0; i < 16; i++) begin
      run_op(1'b0, 8'hE0, 4'd0);
      run_op(1'b1, 8'h00, 4'd1);
    end
    check("c4 heap walk", {16'd0, bus.heap_ptr}, 32'h0FF0);
    check("c4 live walk", {24'd0, bus.live_mask}, 32'h01);
    run_op(1'b0, 8'h10, 4'd0);
    expect_ok("c4 top", 4'd1, 16'h0FF0);
    check("c4 heap top", {16'd0, bus.heap_ptr}, 32'h1000);
    run_op(1'b0, 8'h01, 4'd0);
    expect_err("c4 over", 2'b10);
    check("c4 live kept", {24'd0, bus.live_mask}, 32'h03);
    check("c4 heap kept", {16'd0, bus.heap_ptr}, 32'h1000);

    // 5: argument errors, then free everything
    run_op(1'b1, 8'h00, 4'd5);
    expect_err("c5 not live", 2'b11);
    run_op(1'b1, 8'h00, 4'd9);
    expect_err("c5 range", 2'b11);
    run_op(1'b0, 8'h00, 4'd0);
    expect_err("c5 size0", 2'b11);
    check("c5 live kept", {24'd0, bus.live_mask}, 32'h03);
    run_op(1'b1, 8'h00, 4'd0);
    expect_ok("c5 free0", 4'd0, 16'h0000);
    check("c5 heap partial", {16'd0, bus.heap_ptr}, 32'h1000);
    run_op(1'b1, 8'h00, 4'd1);
    expect_ok("c5 free1", 4'd1, 16'h0000);
    check("c5 live", {24'd0, bus.live_mask}, 32'h00);
    check("c5 heap rewind", {16'd0, bus.heap_ptr}, 32'h0100);

    // 6: reset while tbl_wr is high, req held across it
    run_op(1'b0, 8'h20, 4'd0);
    expect_ok("c6 pre", 4'd0, 16'h0100);
    bus.req = 1'b1; bus.op = 1'b0; bus.size = 8'h30; bus.free_ptr = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("c6 tbl_wr", {31'd0, bus.tbl_wr}, 32'd1);
    check("c6 tbl_ptr", {28'd0, bus.tbl_ptr}, 32'd1);
    check("c6 tbl_loc", {16'd0, bus.tbl_loc}, 32'h0120);
    #2 rst_n = 1'b0;
    #1;
    check("c6 async wr",   {31'd0, bus.tbl_wr}, 32'd0);
    check("c6 async busy", {31'd0, bus.busy}, 32'd0);
    check("c6 async live", {24'd0, bus.live_mask}, 32'h00);
    check("c6 async heap", {16'd0, bus.heap_ptr}, 32'h0100);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check("c6 reaccept busy", {31'd0, bus.busy}, 32'd1);
    @(posedge clk); #1;
    check("c6 wr2", {31'd0, bus.tbl_wr}, 32'd1);
    check("c6 loc2", {16'd0, bus.tbl_loc}, 32'h0100);
    @(posedge clk); #1;
    check("c6 done", {31'd0, bus.done}, 32'd1);
    check("c6 id", {28'd0, bus.obj_id}, 32'd0);
    bus.req = 1'b0;
    @(posedge clk); #1;
    check("c6 idle", {31'd0, bus.busy}, 32'd0);
    check("c6 heap", {16'd0, bus.heap_ptr}, 32'h0130);
    check("c6 live", {24'd0, bus.live_mask}, 32'h01);
    @(posedge clk); #1;
    check("c6 no reaccept", {31'd0, bus.busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
